rotary_operand_sequencer: RTL and testbench



---
 rtl/rotary_operand_sequencer_pkg.sv | 37 +++
 rtl/rotary_operand_sequencer_if.sv | 31 +++
 rtl/rotary_operand_sequencer_quad_decoder.sv | 60 ++++++
 rtl/rotary_operand_sequencer.sv | 115 +++++++++++
 tb/tb_rotary_operand_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rotary_operand_sequencer_pkg.sv
// Shared types and constants for the rotary operand sequencer.
//   step_e    : entry step encoding, shown on the step LEDs
//   dir_e     : rotation direction
//   LO_W      : width of the low operand field (taken straight from holder)
//   step_next : wrap-around step advance in either direction
package rotary_seq_pkg;

  localparam int unsigned LO_W = 4;

  typedef enum logic [2:0] {
    STEP_CLR  = 3'd0,
    STEP_N1HI = 3'd1,
    STEP_N1LO = 3'd2,
    STEP_N2HI = 3'd3,
    STEP_N2LO = 3'd4,
    STEP_CIN  = 3'd5
  } step_e;

  localparam step_e STEP_LAST = STEP_CIN;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  // Encodings 6 and 7 are unreachable: both directions wrap explicitly.
  function automatic step_e step_next(input step_e s, input dir_e d);
    logic [2:0] v;
    v = s;
    if (d == DIR_UP) begin
      step_next = (s == STEP_LAST) ? STEP_CLR : step_e'(v + 3'd1);
    end else begin
      step_next = (s == STEP_CLR) ? STEP_LAST : step_e'(v - 3'd1);
    end
  endfunction

endpackage

// File: rtl/rotary_operand_sequencer_if.sv
// Operand handoff from the sequencer to the adder datapath.
//   num1, num2 : operands (WIDTH bits)
//   cin        : carry/subtract select
//   op_valid   : operand set complete and stable
//   op_ready   : adder side accepts the operand set
// master = sequencer side, slave = adder side.
interface rotary_operand_sequencer_if #(
  parameter int unsigned WIDTH = 7
);
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             cin;
  logic             op_valid;
  logic             op_ready;

  modport master (
    output num1,
    output num2,
    output cin,
    output op_valid,
    input  op_ready
  );

  modport slave (
    input  num1,
    input  num2,
    input  cin,
    input  op_valid,
    output op_ready
  );
endinterface

// File: rtl/rotary_operand_sequencer_quad_decoder.sv
// Quadrature decoder.
//   clk, rst_n   : system clock, async active-low reset
//   rot_a, rot_b : raw quadrature phases, asynchronous to clk
//   evt          : one-cycle pulse per detent (both-high reached after both-low)
//   dir          : direction latched from the most recent single-high phase
module quad_decoder
  import rotary_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rot_a,
  input  logic rot_b,
  output logic evt,
  output dir_e dir
);

  logic a_m, a_s;
  logic b_m, b_s;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_m <= 1'b0;
      a_s <= 1'b0;
      b_m <= 1'b0;
      b_s <= 1'b0;
    end else begin
      a_m <= rot_a;
      a_s <= a_m;
      b_m <= rot_b;
      b_s <= b_m;
    end
  end

  // armed is set only by the both-low rest phase, so bounce around
  // both-high cannot produce a second event within one detent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      evt   <= 1'b0;
      dir   <= DIR_UP;
    end else begin
      evt <= 1'b0;
      if (!a_s && !b_s) begin
        armed <= 1'b1;
      end
      if (a_s && b_s && armed) begin
        evt   <= 1'b1;
        armed <= 1'b0;
      end
      if (!a_s && b_s) begin
        dir <= DIR_UP;
      end
      if (a_s && !b_s) begin
        dir <= DIR_DN;
      end
    end
  end

endmodule

// File: rtl/rotary_operand_sequencer.sv
// Operand entry sequencer for the ripple adder.
// Detents step through 0..5; entering a step captures the switch bank
// into the matching operand field. Entering step 5 presents the operand set
// on op_if with op_valid held until op_ready is seen.
//   clk, rst_n   : system clock, async active-low reset
//   rot_a, rot_b : quadrature phases (asynchronous)
//   holder       : 4-bit switch bank, sampled on step-entry edges only
//   step         : current entry step, for LED display
//   overrun      : sticky, rotary event dropped while op_valid was high
//   op_if        : num1/num2/cin/op_valid out, op_ready in
module rotary_operand_sequencer
  import rotary_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rot_a,
  input  logic                        rot_b,
  input  logic [LO_W-1:0]             holder,
  output logic [2:0]                  step,
  output logic                        overrun,
  rotary_operand_sequencer_if.master  op_if
);

  localparam int unsigned HI_W = WIDTH - LO_W;

  logic             evt;
  dir_e             dir;

  step_e            step_q, step_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic             cin_q, cin_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             accept;
  logic             handshake;

  quad_decoder u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .rot_a (rot_a),
    .rot_b (rot_b),
    .evt   (evt),
    .dir   (dir)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= STEP_CLR;
      num1_q  <= '0;
      num2_q  <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // accept and handshake are exclusive (accept needs op_valid low), so an
  // event coinciding with the handshake is dropped and the overrun clear wins.
  always_comb begin
    step_d    = step_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    cin_d     = cin_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    accept    = evt && !valid_q;
    handshake = valid_q && op_if.op_ready;

    if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else if (evt && valid_q) begin
      ovr_d = 1'b1;
    end

    if (accept) begin
      step_d = step_next(step_q, dir);
      unique case (step_d)
        STEP_CLR: begin
          num1_d  = '0;
          num2_d  = '0;
          cin_d   = 1'b0;
          valid_d = 1'b0;
        end
        STEP_N1HI: num1_d[WIDTH-1:LO_W] = holder[HI_W-1:0];
        STEP_N1LO: num1_d[LO_W-1:0]     = holder;
        STEP_N2HI: num2_d[WIDTH-1:LO_W] = holder[HI_W-1:0];
        STEP_N2LO: num2_d[LO_W-1:0]     = holder;
        STEP_CIN: begin
          cin_d   = holder[0];
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign step           = step_q;
  assign overrun        = ovr_q;
  assign op_if.num1     = num1_q;
  assign op_if.num2     = num2_q;
  assign op_if.cin      = cin_q;
  assign op_if.op_valid = valid_q;

endmodule

// File: tb/tb_rotary_operand_sequencer.sv
module tb_rotary_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rot_a;
  logic       rot_b;
  logic [3:0] holder;
  logic [2:0] step;
  logic       overrun;

  rotary_operand_sequencer_if #(.WIDTH(7)) op_if ();

  rotary_operand_sequencer #(.WIDTH(7)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rot_a   (rot_a),
    .rot_b   (rot_b),
    .holder  (holder),
    .step    (step),
    .overrun (overrun),
    .op_if   (op_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [19:0] vec;   // {step, num1, num2, cin, op_valid, overrun}
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks  = 0;
  int unsigned n_pass    = 0;
  int unsigned n_timeout = 0;
  int unsigned snap_req  = 0;
  int unsigned snap_done = 0;
  bit          mon_en    = 1'b0;

  function automatic void push(input string nm, input logic [2:0] s,
                               input logic [6:0] a, input logic [6:0] b,
                               input logic c, input logic v, input logic o);
    exp_t e;
    e.name = nm;
    e.vec  = {s, a, b, c, v, o};
    exp_q.push_back(e);
  endfunction

  // Monitor: every visible output change consumes one expected entry;
  // a pending snapshot request consumes one while outputs are quiet.
  logic [19:0] cur, prev;
  exp_t        head;
  bit          do_chk;
  string       why;

  always @(negedge clk) begin
    cur    = {step, op_if.num1, op_if.num2, op_if.cin, op_if.op_valid, overrun};
    do_chk = 1'b0;
    if (mon_en) begin
      if (cur != prev) begin
        do_chk = 1'b1;
        why    = "change";
      end else if (snap_req != snap_done) begin
        do_chk = 1'b1;
        why    = "snapshot";
        snap_done++;
      end
    end
    if (do_chk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_%s: got step=%0d num1=%h num2=%h cin=%b valid=%b ovr=%b, no response required",
                 why, cur[19:17], cur[16:10], cur[9:3], cur[2], cur[1], cur[0]);
      end else begin
        head = exp_q.pop_front();
        if (head.vec === cur) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got step=%0d num1=%h num2=%h cin=%b valid=%b ovr=%b, want step=%0d num1=%h num2=%h cin=%b valid=%b ovr=%b",
                   head.name, cur[19:17], cur[16:10], cur[9:3], cur[2], cur[1], cur[0],
                   head.vec[19:17], head.vec[16:10], head.vec[9:3], head.vec[2], head.vec[1], head.vec[0]);
        end
      end
    end
    prev = cur;
  end

  task automatic pins(input logic a, input logic b, input int unsigned n);
    @(posedge clk);
    #1;
    rot_a = a;
    rot_b = b;
    repeat (n - 1) @(posedge clk);
  endtask

  // One detent; with ready_pulse, op_ready is high only on the step-update edge.
  task automatic detent(input bit fwd, input logic [3:0] h, input bit ready_pulse);
    holder = h;
    if (fwd) pins(1'b0, 1'b1, 4);
    else     pins(1'b1, 1'b0, 4);
    @(posedge clk);
    #1;
    rot_a = 1'b1;
    rot_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (ready_pulse) op_ready_set(1'b1);
    @(posedge clk);
    #1;
    if (ready_pulse) op_ready_set(1'b0);
    if (fwd) pins(1'b1, 1'b0, 4);
    else     pins(1'b0, 1'b1, 4);
    pins(1'b0, 1'b0, 4);
  endtask

  task automatic op_ready_set(input logic r);
    op_if.op_ready = r;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_timeout++;
      $display("FAIL drain: %0d required responses not seen, got none within 200 cycles", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic snap(input string nm, input logic [2:0] s, input logic [6:0] a,
                      input logic [6:0] b, input logic c, input logic v, input logic o);
    int unsigned n = 0;
    push(nm, s, a, b, c, v, o);
    snap_req++;
    while (snap_done != snap_req && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (snap_done != snap_req) begin
      n_timeout++;
      $display("FAIL %s: snapshot not taken, required within 20 cycles", nm);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    rot_a          = 1'b0;
    rot_b          = 1'b0;
    holder         = 4'h0;
    op_if.op_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    snap("reset", 3'd0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0);

    // Three forward detents, holder 5 each time
    push("fwd_n1hi", 3'd1, 7'h50, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h5, 0);
    push("fwd_n1lo", 3'd2, 7'h55, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h5, 0);
    push("fwd_n2hi", 3'd3, 7'h55, 7'h50, 1'b0, 1'b0, 1'b0); detent(1, 4'h5, 0);
    drain();

    push("fwd_n2lo", 3'd4, 7'h55, 7'h53, 1'b0, 1'b0, 1'b0); detent(1, 4'h3, 0);
    push("fwd_cin0", 3'd5, 7'h55, 7'h53, 1'b0, 1'b1, 1'b0); detent(1, 4'h0, 0);
    drain();

    // Events while op_valid high: dropped, overrun sticks
    push("overrun_set", 3'd5, 7'h55, 7'h53, 1'b0, 1'b1, 1'b1); detent(1, 4'hF, 0);
    detent(1, 4'hA, 0);
    drain();
    holder = 4'h6;
    snap("overrun_hold", 3'd5, 7'h55, 7'h53, 1'b0, 1'b1, 1'b1);
    push("handshake", 3'd5, 7'h55, 7'h53, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 op_if.op_ready = 1'b1;
    @(posedge clk); #1 op_if.op_ready = 1'b0;
    drain();

    push("wrap_clear", 3'd0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h9, 0);

    // Full entry 2, A, 1, 3, 1
    push("e_n1hi", 3'd1, 7'h20, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h2, 0);
    push("e_n1lo", 3'd2, 7'h2A, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'hA, 0);
    push("e_n2hi", 3'd3, 7'h2A, 7'h10, 1'b0, 1'b0, 1'b0); detent(1, 4'h1, 0);
    push("e_n2lo", 3'd4, 7'h2A, 7'h13, 1'b0, 1'b0, 1'b0); detent(1, 4'h3, 0);
    push("e_cin",  3'd5, 7'h2A, 7'h13, 1'b1, 1'b1, 1'b0); detent(1, 4'h1, 0);
    drain();

    // Overrun, then an event coinciding with the handshake edge
    push("e_overrun",  3'd5, 7'h2A, 7'h13, 1'b1, 1'b1, 1'b1); detent(1, 4'h0, 0);
    push("coincident", 3'd5, 7'h2A, 7'h13, 1'b1, 1'b0, 1'b0); detent(1, 4'h6, 1);
    drain();

    // Backward wrap 0 -> 5 with op_ready already high
    push("to_zero", 3'd0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h4, 0);
    drain();
    op_if.op_ready = 1'b1;
    push("bwd_wrap",   3'd5, 7'h00, 7'h00, 1'b1, 1'b1, 1'b0);
    push("early_rdy",  3'd5, 7'h00, 7'h00, 1'b1, 1'b0, 1'b0);
    detent(0, 4'h1, 0);
    drain();
    op_if.op_ready = 1'b0;
    push("fwd_after_hs", 3'd0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h0, 0);
    drain();

    // One real detent, then glitches that must not step
    holder = 4'hF;
    push("glitch_first", 3'd1, 7'h70, 7'h00, 1'b0, 1'b0, 1'b0);
    pins(1'b0, 1'b1, 4);
    pins(1'b1, 1'b1, 4);
    pins(1'b1, 1'b0, 4);
    pins(1'b1, 1'b1, 4);
    pins(1'b0, 1'b1, 4);
    pins(1'b1, 1'b1, 4);
    holder = 4'h3;
    pins(1'b1, 1'b0, 4);
    pins(1'b0, 1'b0, 4);
    pins(1'b1, 1'b0, 4);
    pins(1'b0, 1'b0, 4);
    drain();
    snap("glitch_none", 3'd1, 7'h70, 7'h00, 1'b0, 1'b0, 1'b0);

    // Async reset mid-entry
    push("pre_rst_n1lo", 3'd2, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'hF, 0);
    push("pre_rst_n2hi", 3'd3, 7'h7F, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h0, 0);
    drain();
    push("async_reset", 3'd0, 7'h00, 7'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drain();
    push("post_rst", 3'd1, 7'h10, 7'h00, 1'b0, 1'b0, 1'b0); detent(1, 4'h1, 0);
    drain();
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
    $finish;
  end

endmodule
